maze_renderer_pipe: RTL and testbench

Parametrised, pipelined successor to the fixed 16x16 maze renderer. Turns vga_sync pixel coordinates into 8-bit RRRGGGBB pixels. Maze and visited-trail bits live in internal storage loaded through a write port, replacing the wide path bus. Configuration is shadowed and applied only at vblank, so frames never tear. Sits between vga_sync and the VGA pins, and realigns hsync/vsync with the pipelined pixel stream.

---
 rtl/maze_pkg.sv | 30 +++
 rtl/maze_tile_mem.sv | 41 ++++
 rtl/maze_renderer_pipe.sv | 243 ++++++++++++++++++++++++
 tb/tb_maze_renderer_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared colour layout, colour constants, tile_shift range, clear FSM encoding
package maze_pkg;

    localparam int R_W = 3;
    localparam int G_W = 3;
    localparam int B_W = 2;

    function automatic logic [7:0] rgb332(input logic [R_W-1:0] r,
                                          input logic [G_W-1:0] g,
                                          input logic [B_W-1:0] b);
        return {r, g, b};
    endfunction

    localparam logic [7:0] COLOR_BG     = rgb332(3'd0, 3'd0, 2'd0);
    localparam logic [7:0] COLOR_WALL   = rgb332(3'd0, 3'd0, 2'd0);
    localparam logic [7:0] COLOR_PATH   = rgb332(3'd7, 3'd7, 2'd3);
    localparam logic [7:0] COLOR_TRAIL  = rgb332(3'd4, 3'd4, 2'd2);
    localparam logic [7:0] COLOR_CHAR   = rgb332(3'd0, 3'd0, 2'd3);
    localparam logic [7:0] COLOR_START  = rgb332(3'd0, 3'd7, 2'd0);
    localparam logic [7:0] COLOR_FINISH = rgb332(3'd7, 3'd0, 2'd0);

    localparam logic [2:0] SHIFT_MIN = 3'd2;
    localparam logic [2:0] SHIFT_MAX = 3'd5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/maze_tile_mem.sv
// rtl/maze_tile_mem.sv - path and visited bit arrays with write, set-visited, clear sweep and async reads
module maze_tile_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic          wr_data,
    input  logic          vis_en,
    input  logic [AW-1:0] vis_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_path,
    output logic          rd_visited
);

    localparam int DEPTH = 1 << AW;

    logic path_q    [DEPTH];
    logic visited_q [DEPTH];

    // Clearing owns both arrays; the other ports are gated off while it runs.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            path_q[clr_addr]    <= 1'b0;
            visited_q[clr_addr] <= 1'b0;
        end else begin
            if (wr_en) begin
                path_q[wr_addr] <= wr_data;
            end
            if (vis_en) begin
                visited_q[vis_addr] <= 1'b1;
            end
        end
    end

    assign rd_path    = path_q[rd_addr];
    assign rd_visited = visited_q[rd_addr];

endmodule

// File: rtl/maze_renderer_pipe.sv
// rtl/maze_renderer_pipe.sv - two-stage maze pixel renderer with vblank-shadowed configuration
module maze_renderer_pipe
    import maze_pkg::*;
#(
    parameter int          MAX_W        = 32,
    parameter int          MAX_H        = 32,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter int          BLINK_LOG2   = 5,
    parameter logic [15:0] SPRITE       = 16'h6FF6,
    parameter logic [7:0]  BG_COLOR     = COLOR_BG,
    parameter logic [7:0]  WALL_COLOR   = COLOR_WALL,
    parameter logic [7:0]  PATH_COLOR   = COLOR_PATH,
    parameter logic [7:0]  TRAIL_COLOR  = COLOR_TRAIL,
    parameter logic [7:0]  CHAR_COLOR   = COLOR_CHAR,
    parameter logic [7:0]  START_COLOR  = COLOR_START,
    parameter logic [7:0]  FINISH_COLOR = COLOR_FINISH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [9:0]                 pixel_x,
    input  logic [9:0]                 pixel_y,
    input  logic                       video_on,
    input  logic                       hsync_in,
    input  logic                       vsync_in,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_W)-1:0]   wr_x,
    input  logic [$clog2(MAX_H)-1:0]   wr_y,
    input  logic                       wr_data,
    input  logic                       clear,
    input  logic                       trail_en,
    input  logic [$clog2(MAX_W):0]     maze_width,
    input  logic [$clog2(MAX_H):0]     maze_height,
    input  logic [2:0]                 tile_shift,
    input  logic [$clog2(MAX_W)-1:0]   char_x,
    input  logic [$clog2(MAX_H)-1:0]   char_y,
    input  logic [$clog2(MAX_W)-1:0]   start_x,
    input  logic [$clog2(MAX_H)-1:0]   start_y,
    input  logic [$clog2(MAX_W)-1:0]   finish_x,
    input  logic [$clog2(MAX_H)-1:0]   finish_y,
    output logic                       hsync,
    output logic                       vsync,
    output logic [7:0]                 rgb,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int XW = $clog2(MAX_W);
    localparam int YW = $clog2(MAX_H);
    localparam int AW = XW + YW;
    localparam int CW = 16;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_W * MAX_H - 1);

    // Clear FSM
    clr_state_e    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          idle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign idle = (state_q == ST_IDLE);
    assign busy = !idle;

    // Shadow configuration, refreshed once per frame at the start of vblank
    logic [CW-1:0]         pxw_d, pxh_d, bx_d, by_d;
    logic                  err_d, latch;
    logic [CW-1:0]         pxw_q, pxh_q, bx_q, by_q;
    logic [2:0]            shift_q;
    logic                  cfg_err_q, trail_q;
    logic [XW-1:0]         char_x_q, start_x_q, finish_x_q;
    logic [YW-1:0]         char_y_q, start_y_q, finish_y_q;
    logic [BLINK_LOG2-1:0] frame_q;

    always_comb begin
        latch = (pixel_x == 10'd0) && (pixel_y == 10'(V_ACTIVE));
        pxw_d = CW'(maze_width) << tile_shift;
        pxh_d = CW'(maze_height) << tile_shift;
        bx_d  = (CW'(H_ACTIVE) - pxw_d) >> 1;
        by_d  = (CW'(V_ACTIVE) - pxh_d) >> 1;
        err_d = (tile_shift < SHIFT_MIN) || (tile_shift > SHIFT_MAX) ||
                (pxw_d > CW'(H_ACTIVE)) || (pxh_d > CW'(V_ACTIVE)) ||
                (maze_width > (XW+1)'(MAX_W)) || (maze_height > (YW+1)'(MAX_H));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pxw_q      <= '0;
            pxh_q      <= '0;
            bx_q       <= '0;
            by_q       <= '0;
            shift_q    <= '0;
            cfg_err_q  <= 1'b0;
            trail_q    <= 1'b0;
            char_x_q   <= '0;
            char_y_q   <= '0;
            start_x_q  <= '0;
            start_y_q  <= '0;
            finish_x_q <= '0;
            finish_y_q <= '0;
            frame_q    <= '0;
        end else if (latch) begin
            pxw_q      <= pxw_d;
            pxh_q      <= pxh_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            shift_q    <= tile_shift;
            cfg_err_q  <= err_d;
            trail_q    <= trail_en;
            char_x_q   <= char_x;
            char_y_q   <= char_y;
            start_x_q  <= start_x;
            start_y_q  <= start_y;
            finish_x_q <= finish_x;
            finish_y_q <= finish_y;
            frame_q    <= frame_q + 1'b1;
        end
    end

    assign cfg_err = cfg_err_q;

    // Stage 1: pixel to tile / sub-tile coordinates
    logic [CW-1:0] px, py, dx, dy, sub_mask;
    logic [2:0]    sub_sh;
    logic          in_x, in_y;

    always_comb begin
        px       = CW'(pixel_x);
        py       = CW'(pixel_y);
        dx       = px - bx_q;
        dy       = py - by_q;
        sub_mask = (CW'(1) << shift_q) - CW'(1);
        sub_sh   = shift_q - 3'd2;
        in_x     = (px >= bx_q) && (dx < pxw_q);
        in_y     = (py >= by_q) && (dy < pxh_q);
    end

    logic          en_s1_q, vid_s1_q, hs_s1_q, vs_s1_q, in_s1_q;
    logic [XW-1:0] tx_q;
    logic [YW-1:0] ty_q;
    logic [1:0]    sx_q, sy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_s1_q  <= 1'b0;
            vid_s1_q <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            in_s1_q  <= 1'b0;
            tx_q     <= '0;
            ty_q     <= '0;
            sx_q     <= '0;
            sy_q     <= '0;
        end else begin
            en_s1_q  <= enable;
            vid_s1_q <= video_on;
            hs_s1_q  <= hsync_in;
            vs_s1_q  <= vsync_in;
            in_s1_q  <= in_x && in_y;
            tx_q     <= XW'(dx >> shift_q);
            ty_q     <= YW'(dy >> shift_q);
            sx_q     <= 2'((dx & sub_mask) >> sub_sh);
            sy_q     <= 2'((dy & sub_mask) >> sub_sh);
        end
    end

    logic rd_path, rd_vis;

    maze_tile_mem #(.AW(AW)) u_tile_mem (
        .clk        (clk),
        .wr_en      (wr_en && idle),
        .wr_addr    ({wr_y, wr_x}),
        .wr_data    (wr_data),
        .vis_en     (idle),
        .vis_addr   ({char_y, char_x}),
        .clr_en     (!idle),
        .clr_addr   (clr_addr_q),
        .rd_addr    ({ty_q, tx_q}),
        .rd_path    (rd_path),
        .rd_visited (rd_vis)
    );

    // Stage 2: colour priority
    logic [7:0] rgb_d;
    logic       sprite_on;

    always_comb begin
        rgb_d     = WALL_COLOR;
        sprite_on = SPRITE[{sy_q, sx_q}];
        if (!en_s1_q || !vid_s1_q || cfg_err_q || !in_s1_q) begin
            rgb_d = BG_COLOR;
        end else if (tx_q == char_x_q && ty_q == char_y_q && sprite_on) begin
            rgb_d = CHAR_COLOR;
        end else if (tx_q == start_x_q && ty_q == start_y_q) begin
            rgb_d = START_COLOR;
        end else if (tx_q == finish_x_q && ty_q == finish_y_q && !frame_q[BLINK_LOG2-1]) begin
            rgb_d = FINISH_COLOR;
        end else if (rd_path) begin
            rgb_d = (trail_q && rd_vis) ? TRAIL_COLOR : PATH_COLOR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb   <= '0;
            hsync <= 1'b0;
            vsync <= 1'b0;
        end else begin
            rgb   <= rgb_d;
            hsync <= hs_s1_q;
            vsync <= vs_s1_q;
        end
    end

endmodule

// File: tb/tb_maze_renderer_pipe.sv
// tb/tb_maze_renderer_pipe.sv - directed scoreboard bench for maze_renderer_pipe
module tb_maze_renderer_pipe;

    logic       clk = 1'b0;
    logic       reset, enable, video_on, hsync_in, vsync_in;
    logic [9:0] pixel_x, pixel_y;
    logic       wr_en, wr_data, clear, trail_en;
    logic [4:0] wr_x, wr_y, char_x, char_y, start_x, start_y, finish_x, finish_y;
    logic [5:0] maze_width, maze_height;
    logic [2:0] tile_shift;
    logic       hsync, vsync, busy, cfg_err;
    logic [7:0] rgb;

    int checks = 0;
    int errors = 0;
    int fcnt   = 0;

    typedef struct {
        bit         chk;
        logic [7:0] rgb;
        logic       hs;
        logic       vs;
    } sb_t;

    sb_t   sbq  [$];
    string tagq [$];

    always #5 clk = ~clk;

    maze_renderer_pipe dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .clear(clear), .trail_en(trail_en),
        .maze_width(maze_width), .maze_height(maze_height), .tile_shift(tile_shift),
        .char_x(char_x), .char_y(char_y), .start_x(start_x), .start_y(start_y),
        .finish_x(finish_x), .finish_y(finish_y),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .busy(busy), .cfg_err(cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: push the expectation for the current inputs, retire the one from the previous clock.
    task automatic step(input bit chk, input logic [7:0] exp, input string tag);
        sb_t e;
        string t;
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
        e.chk = chk; e.rgb = exp; e.hs = hsync_in; e.vs = vsync_in;
        sbq.push_back(e);
        tagq.push_back(tag);
        @(posedge clk); #1;
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            t = tagq.pop_front();
            if (e.chk) begin
                check({t, "_rgb"}, 32'(rgb), 32'(e.rgb));
                check({t, "_hsync"}, 32'(hsync), 32'(e.hs));
                check({t, "_vsync"}, 32'(vsync), 32'(e.vs));
            end
        end
    endtask

    task automatic pix(input int x, input int y, input logic [7:0] exp, input string tag);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = 1'b1;
        step(1'b1, exp, tag);
        step(1'b0, 8'h00, "idle");
    endtask

    task automatic vblank();
        pixel_x = 10'd0; pixel_y = 10'd480; video_on = 1'b0;
        step(1'b0, 8'h00, "latch");
        fcnt++;
    endtask

    task automatic write_tile(input int x, input int y, input logic d);
        wr_en = 1'b1; wr_x = 5'(x); wr_y = 5'(y); wr_data = d;
        step(1'b0, 8'h00, "wr");
        wr_en = 1'b0;
    endtask

    initial begin
        int cnt;
        reset = 1'b1; enable = 1'b1; video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        pixel_x = 10'd320; pixel_y = 10'd240;
        wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = 1'b0; clear = 1'b0; trail_en = 1'b0;
        maze_width = 6'd8; maze_height = 6'd8; tile_shift = 3'd4;
        char_x = 5'd1; char_y = 5'd1; start_x = 5'd0; start_y = 5'd7;
        finish_x = 5'd7; finish_y = 5'd7;

        // Reset asserted mid-frame
        #2 reset = 1'b0;
        step(1'b0, 8'h00, "rst");
        step(1'b0, 8'h00, "rst");
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync", 32'(hsync), 32'h0);
        check("rst_vsync", 32'(vsync), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cfg_err", 32'(cfg_err), 32'h0);
        reset = 1'b1;
        pix(320, 240, 8'h00, "pre_latch_a");
        pix(305, 209, 8'h00, "pre_latch_b");

        // Clear sweep; a write during it must be dropped
        pixel_x = 10'd100; pixel_y = 10'd100;
        clear = 1'b1;
        step(1'b0, 8'h00, "clr");
        clear = 1'b0;
        cnt = 0;
        for (int i = 0; i < 2000 && busy; i++) begin
            cnt++;
            wr_en = (cnt == 500); wr_x = 5'd3; wr_y = 5'd2; wr_data = 1'b1;
            if (cnt == 600) clear = 1'b1; else clear = 1'b0;
            step(1'b0, 8'h00, "clearing");
        end
        wr_en = 1'b0; clear = 1'b0;
        check("busy_cycles", 32'(cnt), 32'd1024);
        check("busy_done", 32'(busy), 32'h0);

        // 8x8 tiles of 16 px: bx=256, by=176
        vblank();
        check("cfg_err_legal", 32'(cfg_err), 32'h0);
        pix(305, 209, 8'h00, "clear_wr_ignored");
        write_tile(3, 2, 1'b1);
        write_tile(1, 1, 1'b1);
        write_tile(7, 7, 1'b1);
        write_tile(0, 2, 1'b1);
        write_tile(7, 2, 1'b1);
        pix(305, 209, 8'hFF, "path_3_2");
        pix(320, 209, 8'h00, "wall_4_2");
        pix(100, 100, 8'h00, "outside");
        pix(256, 209, 8'hFF, "left_edge_in");
        pix(255, 209, 8'h00, "left_edge_out");
        pix(383, 209, 8'hFF, "right_edge_in");
        pix(384, 209, 8'h00, "right_edge_out");
        pixel_x = 10'd305; pixel_y = 10'd209; video_on = 1'b0;
        step(1'b1, 8'h00, "video_off");
        step(1'b0, 8'h00, "idle");
        enable = 1'b0;
        pix(305, 209, 8'h00, "disabled");
        enable = 1'b1;
        pix(305, 209, 8'hFF, "reenabled");

        // Character sprite on path tile (1,1)
        pix(272, 192, 8'hFF, "char_sub00");
        pix(276, 192, 8'h03, "char_sub10");
        pix(272, 196, 8'h03, "char_sub01");
        pix(284, 192, 8'hFF, "char_sub30");
        char_x = 5'd2; trail_en = 1'b1;
        step(1'b0, 8'h00, "move");
        vblank();
        pix(272, 192, 8'h92, "trail_1_1");
        pix(276, 192, 8'h92, "trail_1_1_b");

        // Finish blink, 32-frame period
        pix(369, 289, ((fcnt >> 4) & 1) != 0 ? 8'hFF : 8'hE0, "finish_f2");
        for (int f = 0; f < 31; f++) begin
            vblank();
            pix(369, 289, ((fcnt >> 4) & 1) != 0 ? 8'hFF : 8'hE0, $sformatf("finish_f%0d", fcnt));
        end
        start_x = 5'd7; start_y = 5'd7;
        vblank();
        pix(369, 289, 8'h1C, "start_eq_finish_a");
        while (((fcnt >> 4) & 1) == 0) vblank();
        pix(369, 289, 8'h1C, "start_eq_finish_b");

        // Illegal configuration only takes effect at vblank
        maze_width = 6'd32; tile_shift = 3'd5;
        pix(305, 209, 8'hFF, "midframe_unchanged");
        check("cfg_err_midframe", 32'(cfg_err), 32'h0);
        vblank();
        check("cfg_err_too_wide", 32'(cfg_err), 32'h1);
        pix(305, 209, 8'h00, "err_bg_a");
        pix(0, 0, 8'h00, "err_bg_b");
        maze_width = 6'd8; tile_shift = 3'd4;
        pix(305, 209, 8'h00, "err_holds_midframe");
        check("cfg_err_held", 32'(cfg_err), 32'h1);
        vblank();
        check("cfg_err_restored", 32'(cfg_err), 32'h0);
        pix(305, 209, 8'hFF, "restored_path");
        tile_shift = 3'd1;
        vblank();
        check("cfg_err_shift1", 32'(cfg_err), 32'h1);
        tile_shift = 3'd6;
        vblank();
        check("cfg_err_shift6", 32'(cfg_err), 32'h1);
        tile_shift = 3'd2; maze_width = 6'd32;
        vblank();
        check("cfg_err_w32", 32'(cfg_err), 32'h0);
        maze_width = 6'd33;
        vblank();
        check("cfg_err_w33", 32'(cfg_err), 32'h1);
        maze_width = 6'd8; tile_shift = 3'd4;
        vblank();
        check("cfg_err_final", 32'(cfg_err), 32'h0);

        // Reset in the middle of a clear
        clear = 1'b1;
        step(1'b0, 8'h00, "clr2");
        clear = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, "clearing2");
        check("busy_midclear", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        check("rst_midclear_busy", 32'(busy), 32'h0);
        check("rst_midclear_rgb", 32'(rgb), 32'h0);
        check("rst_midclear_cfg_err", 32'(cfg_err), 32'h0);
        step(1'b0, 8'h00, "rst2");
        reset = 1'b1;
        step(1'b0, 8'h00, "rst2");
        check("busy_after_rst", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
